powerup_scheduler: RTL and testbench

Sequences the Pong power-up life cycle: cooldown, spawn of a randomly chosen power-up, arbitration when both paddles claim it, and the timed effect on the winning player. It sits between the collision logic (hit pulses) and the paddle/ball datapath (per-player one-hot effect vectors), and replaces ad-hoc per-mode load pulses with a single owner-aware controller. Exactly one power-up is in play at any time.

---
 rtl/powerup_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_powerup_scheduler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/powerup_scheduler.sv
// Pong power-up controller: cooldown, random spawn, paddle arbitration
// and the timed per-player effect with expiry warning.
module powerup_scheduler #(
    parameter int unsigned TICK_DIV    = 50000000,
    parameter int unsigned SPAWN_DELAY = 3,
    parameter int unsigned SHOW_SECS   = 6,
    parameter int unsigned DUR0        = 1,
    parameter int unsigned DUR1        = 2,
    parameter int unsigned DUR2        = 4,
    parameter int unsigned DUR3        = 4,
    parameter int unsigned WARN_SECS   = 2,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       game_run,
    input  logic       round_end,
    input  logic       hit_p1,
    input  logic       hit_p2,
    output logic       spawn_valid,
    output logic [1:0] spawn_mode,
    output logic [3:0] effect_p1,
    output logic [3:0] effect_p2,
    output logic       warning,
    output logic [3:0] remaining
);

    typedef enum logic [1:0] {
        COOLDOWN,
        SHOWN,
        ACTIVE
    } state_t;

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX   = PW'(TICK_DIV - 1);
    localparam logic [7:0]   SEED       = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [7:0]   SPAWN_LAST = 8'(SPAWN_DELAY - 1);
    localparam logic [7:0]   SHOW_LAST  = 8'(SHOW_SECS - 1);
    localparam logic [3:0]   WARN       = 4'(WARN_SECS);

    state_t        state;
    state_t        state_nx;
    logic [PW-1:0] presc;
    logic [7:0]    secs;
    logic [7:0]    lfsr;
    logic          ptr;
    logic          tick;
    logic          hit_any;
    logic          grant_p2;
    logic          enter;
    logic [3:0]    dur_sel;
    logic [3:0]    onehot;

    logic       spawn_valid_nx;
    logic [1:0] spawn_mode_nx;
    logic [3:0] effect_p1_nx;
    logic [3:0] effect_p2_nx;
    logic [3:0] remaining_nx;
    logic       warning_nx;
    logic       ptr_nx;

    assign tick     = game_run && (presc == PRE_MAX);
    assign hit_any  = game_run && (hit_p1 || hit_p2);
    // ptr = 0 names P1; a double claim goes to whoever ptr names
    assign grant_p2 = (hit_p1 && hit_p2) ? ptr : hit_p2;
    assign enter    = round_end || (state_nx != state);
    assign onehot   = 4'b0001 << spawn_mode;

    always_comb begin
        dur_sel = 4'(DUR3);
        unique case (spawn_mode)
            2'd0:    dur_sel = 4'(DUR0);
            2'd1:    dur_sel = 4'(DUR1);
            2'd2:    dur_sel = 4'(DUR2);
            default: dur_sel = 4'(DUR3);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= COOLDOWN;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (round_end) begin
            state_nx = COOLDOWN;
        end else begin
            unique case (state)
                COOLDOWN: begin
                    if (tick && secs == SPAWN_LAST)
                        state_nx = SHOWN;
                end
                SHOWN: begin
                    if (hit_any)
                        state_nx = ACTIVE;
                    else if (tick && secs == SHOW_LAST)
                        state_nx = COOLDOWN;
                end
                ACTIVE: begin
                    if (tick && remaining == 4'd1)
                        state_nx = COOLDOWN;
                end
                default: state_nx = COOLDOWN;
            endcase
        end
    end

    always_comb begin
        spawn_valid_nx = spawn_valid;
        spawn_mode_nx  = spawn_mode;
        effect_p1_nx   = effect_p1;
        effect_p2_nx   = effect_p2;
        remaining_nx   = remaining;
        ptr_nx         = ptr;
        if (round_end) begin
            spawn_valid_nx = 1'b0;
            effect_p1_nx   = 4'd0;
            effect_p2_nx   = 4'd0;
            remaining_nx   = 4'd0;
        end else begin
            unique case (state)
                COOLDOWN: begin
                    if (state_nx == SHOWN) begin
                        spawn_valid_nx = 1'b1;
                        spawn_mode_nx  = lfsr[1:0];
                    end
                end
                SHOWN: begin
                    if (hit_any) begin
                        spawn_valid_nx = 1'b0;
                        remaining_nx   = dur_sel;
                        effect_p1_nx   = grant_p2 ? 4'd0 : onehot;
                        effect_p2_nx   = grant_p2 ? onehot : 4'd0;
                        if (hit_p1 && hit_p2)
                            ptr_nx = ~ptr;
                    end else if (state_nx == COOLDOWN) begin
                        spawn_valid_nx = 1'b0;
                    end
                end
                ACTIVE: begin
                    if (tick) begin
                        remaining_nx = remaining - 4'd1;
                        if (state_nx == COOLDOWN) begin
                            effect_p1_nx = 4'd0;
                            effect_p2_nx = 4'd0;
                        end
                    end
                end
                default: ;
            endcase
        end
        warning_nx = (state_nx == ACTIVE) && (remaining_nx != 4'd0)
                     && (remaining_nx <= WARN);
    end

    // prescaler and second counter restart on every state entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc       <= '0;
            secs        <= 8'd0;
            lfsr        <= SEED;
            ptr         <= 1'b0;
            spawn_valid <= 1'b0;
            spawn_mode  <= 2'd0;
            effect_p1   <= 4'd0;
            effect_p2   <= 4'd0;
            remaining   <= 4'd0;
            warning     <= 1'b0;
        end else begin
            if (game_run)
                lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (enter) begin
                presc <= '0;
                secs  <= 8'd0;
            end else if (game_run) begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick)
                    secs <= secs + 8'd1;
            end
            ptr         <= ptr_nx;
            spawn_valid <= spawn_valid_nx;
            spawn_mode  <= spawn_mode_nx;
            effect_p1   <= effect_p1_nx;
            effect_p2   <= effect_p2_nx;
            remaining   <= remaining_nx;
            warning     <= warning_nx;
        end
    end

endmodule

// File: tb/tb_powerup_scheduler.sv
// Bench for powerup_scheduler: elapsed-time reference model, directed
// life-cycle scenarios, then randomized play.
module tb_powerup_scheduler;

    localparam int TD    = 4;
    localparam int SPAWN = 3;
    localparam int SHOW  = 6;
    localparam int WARN  = 2;
    localparam int CD = 0, SH = 1, AC = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       game_run = 1'b0;
    logic       round_end = 1'b0;
    logic       hit_p1 = 1'b0;
    logic       hit_p2 = 1'b0;
    logic       spawn_valid;
    logic [1:0] spawn_mode;
    logic [3:0] effect_p1;
    logic [3:0] effect_p2;
    logic       warning;
    logic [3:0] remaining;

    powerup_scheduler #(
        .TICK_DIV(TD), .SPAWN_DELAY(SPAWN), .SHOW_SECS(SHOW),
        .DUR0(1), .DUR1(2), .DUR2(4), .DUR3(4),
        .WARN_SECS(WARN), .LFSR_SEED(8'hA5)
    ) dut (
        .clk(clk), .reset(reset), .game_run(game_run),
        .round_end(round_end), .hit_p1(hit_p1), .hit_p2(hit_p2),
        .spawn_valid(spawn_valid), .spawn_mode(spawn_mode),
        .effect_p1(effect_p1), .effect_p2(effect_p2),
        .warning(warning), .remaining(remaining)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    // model: phase plus run-cycles elapsed since entering it
    int         m_phase;
    int         m_el;
    logic [7:0] m_lfsr;
    logic       m_ptr;
    logic       m_own;
    logic [1:0] m_mode;

    function automatic int dur(input logic [1:0] m);
        case (m)
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = CD;
        m_el    = 0;
        m_lfsr  = 8'hA5;
        m_ptr   = 1'b0;
        m_own   = 1'b0;
        m_mode  = 2'd0;
    endtask

    task automatic model_step();
        logic [7:0] old;
        if (!reset) return;
        old = m_lfsr;
        if (game_run)
            m_lfsr = {old[6:0], old[7] ^ old[5] ^ old[4] ^ old[3]};
        if (round_end) begin
            m_phase = CD;
            m_el = 0;
        end else if (game_run) begin
            m_el++;
            if (m_phase == CD) begin
                if (m_el == SPAWN * TD) begin
                    m_phase = SH;
                    m_el = 0;
                    m_mode = old[1:0];
                end
            end else if (m_phase == SH) begin
                if (hit_p1 || hit_p2) begin
                    if (hit_p1 && hit_p2) begin
                        m_own = m_ptr;
                        m_ptr = ~m_ptr;
                    end else begin
                        m_own = hit_p2;
                    end
                    m_phase = AC;
                    m_el = 0;
                end else if (m_el == SHOW * TD) begin
                    m_phase = CD;
                    m_el = 0;
                end
            end else if (m_el == dur(m_mode) * TD) begin
                m_phase = CD;
                m_el = 0;
            end
        end
    endtask

    function automatic logic [3:0] exp_rem();
        if (m_phase != AC) return 4'd0;
        return 4'(dur(m_mode) - m_el / TD);
    endfunction

    function automatic logic [3:0] exp_eff(input logic p2);
        if (m_phase != AC || m_own != p2) return 4'd0;
        return 4'b0001 << m_mode;
    endfunction

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic compare_all();
        logic [3:0] r;
        r = exp_rem();
        chk("spawn_valid", {7'd0, spawn_valid}, {7'd0, m_phase == SH});
        chk("spawn_mode", {6'd0, spawn_mode}, {6'd0, m_mode});
        chk("effect_p1", {4'd0, effect_p1}, {4'd0, exp_eff(1'b0)});
        chk("effect_p2", {4'd0, effect_p2}, {4'd0, exp_eff(1'b1)});
        chk("remaining", {4'd0, remaining}, {4'd0, r});
        chk("warning", {7'd0, warning},
            {7'd0, (r >= 4'd1) && (r <= 4'(WARN))});
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    task automatic wait_spawn();
        int n = 0;
        while (!spawn_valid && n < 300) begin
            cycle();
            n++;
        end
        chk("spawn_timeout", {7'd0, spawn_valid}, 8'd1);
    endtask

    task automatic pulse_hit(input logic a, input logic b);
        hit_p1 = a;
        hit_p2 = b;
        cycle();
        hit_p1 = 1'b0;
        hit_p2 = 1'b0;
    endtask

    initial begin
        int g;
        int n;
        int lim;
        model_reset();
        game_run = 1'b1;
        #1 compare_all();
        repeat (2) cycle();
        reset = 1'b1;

        // first spawn 12 cycles after release, seed A5 gives mode 3
        repeat (11) cycle();
        chk("lit_spawn_early", {7'd0, spawn_valid}, 8'd0);
        cycle();
        chk("lit_spawn_at12", {7'd0, spawn_valid}, 8'd1);
        chk("lit_spawn_mode", {6'd0, spawn_mode}, 8'd3);

        pulse_hit(1'b1, 1'b0);
        chk("lit_grant_eff1", {4'd0, effect_p1}, 8'h08);
        chk("lit_grant_eff2", {4'd0, effect_p2}, 8'h00);
        chk("lit_grant_rem", {4'd0, remaining}, 8'd4);
        chk("lit_grant_sv", {7'd0, spawn_valid}, 8'd0);
        repeat (7) cycle();
        chk("lit_warn_off", {7'd0, warning}, 8'd0);
        cycle();
        chk("lit_rem2", {4'd0, remaining}, 8'd2);
        chk("lit_warn_on", {7'd0, warning}, 8'd1);
        repeat (7) cycle();
        chk("lit_eff_before", {4'd0, effect_p1}, 8'h08);
        cycle();
        chk("lit_eff_cleared", {4'd0, effect_p1}, 8'h00);
        repeat (11) cycle();
        chk("lit_respawn_early", {7'd0, spawn_valid}, 8'd0);
        cycle();
        chk("lit_respawn", {7'd0, spawn_valid}, 8'd1);

        // arbitration: double claim P1, double claim P2, single, double P1
        pulse_hit(1'b1, 1'b1);
        chk("lit_arb1", {6'd0, effect_p1 != 0, effect_p2 != 0}, 8'b10);
        wait_spawn();
        pulse_hit(1'b1, 1'b1);
        chk("lit_arb2", {6'd0, effect_p1 != 0, effect_p2 != 0}, 8'b01);
        wait_spawn();
        pulse_hit(1'b0, 1'b1);
        chk("lit_single_p2", {6'd0, effect_p1 != 0, effect_p2 != 0}, 8'b01);
        wait_spawn();
        pulse_hit(1'b1, 1'b1);
        chk("lit_arb3", {6'd0, effect_p1 != 0, effect_p2 != 0}, 8'b10);

        // unclaimed power-up despawns after 24 cycles
        wait_spawn();
        repeat (23) cycle();
        chk("lit_shown_hold", {7'd0, spawn_valid}, 8'd1);
        cycle();
        chk("lit_despawn", {7'd0, spawn_valid}, 8'd0);
        chk("lit_despawn_eff", {effect_p1, effect_p2}, 8'd0);

        // round_end lands on the expiry edge
        wait_spawn();
        pulse_hit(1'b1, 1'b0);
        lim = dur(m_mode) * TD - 1;
        n = 0;
        while (m_el < lim && n < 100) begin
            cycle();
            n++;
        end
        round_end = 1'b1;
        hit_p2 = 1'b1;
        cycle();
        round_end = 1'b0;
        hit_p2 = 1'b0;
        chk("lit_rend_out", {spawn_valid, warning, effect_p1 | effect_p2,
            remaining[1:0]}, 8'd0);
        chk("lit_rend_rem", {4'd0, remaining}, 8'd0);
        pulse_hit(1'b1, 1'b0);
        chk("lit_cd_hit", {effect_p1, effect_p2}, 8'd0);

        // 10-cycle pause mid-effect delays expiry by exactly 10
        wait_spawn();
        pulse_hit(1'b0, 1'b1);
        g = cyc;
        lim = dur(m_mode) * TD + 10;
        repeat (2) cycle();
        game_run = 1'b0;
        repeat (10) cycle();
        game_run = 1'b1;
        n = 0;
        while (effect_p2 != 0 && n < 100) begin
            cycle();
            n++;
        end
        chk("lit_pause_len", 8'(cyc - g), 8'(lim));

        // asynchronous reset mid-effect
        wait_spawn();
        pulse_hit(1'b1, 1'b0);
        repeat (3) cycle();
        reset = 1'b0;
        #1;
        chk("lit_rst_eff", {effect_p1, effect_p2}, 8'd0);
        chk("lit_rst_rem", {3'd0, spawn_valid, remaining}, 8'd0);
        model_reset();
        repeat (2) cycle();
        reset = 1'b1;
        repeat (12) cycle();
        chk("lit_rst_spawn", {7'd0, spawn_valid}, 8'd1);

        // randomized play
        for (int i = 0; i < 3000; i++) begin
            game_run  = ($urandom_range(0, 9) != 0);
            hit_p1    = ($urandom_range(0, 5) == 0);
            hit_p2    = ($urandom_range(0, 5) == 0);
            round_end = ($urandom_range(0, 149) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
